// File: rtl/hic_pkg.sv
// Shared definitions for the HIC serial chain.
//  - Mode encoding carried on min/mout between HIC stages.
//  - Receive-side control state encoding. The encoding is {pvalid, busy},
//    so both flags can be read straight off the state register.
package hic_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ABORT  = 2'b10;
    localparam logic [1:0] MODE_RESYNC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,  // no word held, no partial word
        ST_COLLECT      = 2'b01,  // partial word, nothing held
        ST_FULL         = 2'b10,  // word held, no partial word
        ST_COLLECT_FULL = 2'b11   // word held and partial word in progress
    } rx_state_t;

endpackage

// File: rtl/hic_rx_shreg.sv
// WIDTH-bit shift-in register for the HIC receive end.
//  clk        rising-edge clock
//  clr        synchronous clear (wins over en)
//  en         shift sin in this edge
//  sin        serial data bit
//  q          current register contents
//  nxt        value the register takes if en=1 this edge; lets the parent
//             capture a completed word including the bit being sampled now
// MSB_FIRST=0: bits enter at the top and move down, so the first bit ends in
// q[0] after WIDTH shifts. MSB_FIRST=1: bits enter at the bottom and move up.
module hic_rx_shreg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    generate
        if (WIDTH == 1) begin : g_w1
            assign nxt = sin;
        end else if (MSB_FIRST) begin : g_msb
            assign nxt = {q[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign nxt = {sin, q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= nxt;
    end

endmodule

// File: rtl/hic_serial_rx.sv
// Receive end of the HIC serial chain: reassembles WIDTH-bit words from the
// upstream serial bit and mode pair and offers them on a valid/ack handshake.
//  clk     rising-edge clock
//  rst     synchronous active-high reset
//  sin     serial data bit (upstream cout)
//  min     upstream mode: 00 hold, 01 shift, 10 abort, 11 resync
//  pack    consumer takes pout this cycle
//  pout    last completed word
//  pvalid  pout holds an unconsumed word
//  ovf     sticky: a word completed over an unconsumed one
//  busy    partial word in progress
//  bcnt    bits collected in the current word
module hic_serial_rx
    import hic_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic [1:0]       min,
    input  logic             pack,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic             ovf,
    output logic             busy,
    output logic [CW-1:0]    bcnt
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    rx_state_t        state, state_next;
    logic             shift, flush, complete, full_next, part_next;
    logic [WIDTH-1:0] sr_q, sr_nxt;

    // Cleared on completion too, so the next word always starts from zero.
    hic_rx_shreg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk (clk),
        .clr (rst | flush | complete),
        .en  (shift),
        .sin (sin),
        .q   (sr_q),
        .nxt (sr_nxt)
    );

    assign pvalid = state[1];
    assign busy   = state[0];

    always_comb begin
        shift      = (min == MODE_SHIFT);
        flush      = (min == MODE_ABORT) || (min == MODE_RESYNC);
        complete   = shift && (bcnt == LAST);
        // A completion always leaves a word held; otherwise pack consumes it.
        full_next  = complete || (pvalid && !pack);
        part_next  = busy;
        if (flush)
            part_next = 1'b0;
        else if (shift)
            part_next = !complete;
        state_next = state;
        case ({full_next, part_next})
            2'b00:   state_next = ST_IDLE;
            2'b01:   state_next = ST_COLLECT;
            2'b10:   state_next = ST_FULL;
            default: state_next = ST_COLLECT_FULL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
            pout <= '0;
            ovf  <= 1'b0;
        end else begin
            if (flush || complete)
                bcnt <= '0;
            else if (shift)
                bcnt <= bcnt + ONE;

            if (complete)
                pout <= sr_nxt;

            // Overflow only when the held word is still unconsumed.
            if (min == MODE_RESYNC)
                ovf <= 1'b0;
            else if (complete && pvalid && !pack)
                ovf <= 1'b1;
        end
    end

    // Keep the register contents observable for lint; the word is taken via nxt.
    logic unused_sr;
    assign unused_sr = ^sr_q;

endmodule

// File: tb/tb_hic_serial_rx.sv
module tb_hic_serial_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, sin, pack;
    logic [1:0]   min;
    logic [W-1:0] pout0, pout1;
    logic         pvalid0, pvalid1, ovf0, ovf1, busy0, busy1;
    logic [3:0]   bcnt0, bcnt1;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    hic_serial_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .min(min), .pack(pack),
        .pout(pout0), .pvalid(pvalid0), .ovf(ovf0), .busy(busy0), .bcnt(bcnt0));

    hic_serial_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .min(min), .pack(pack),
        .pout(pout1), .pvalid(pvalid1), .ovf(ovf1), .busy(busy1), .bcnt(bcnt1));

    // Behavioural model: collected bits kept as a queue, words assembled by index.
    bit           bits_q[$];
    logic [W-1:0] m_pout_l, m_pout_m;
    logic         m_pvalid, m_ovf;

    always @(posedge clk) begin
        if (rst) begin
            bits_q.delete();
            m_pout_l = '0; m_pout_m = '0; m_pvalid = 0; m_ovf = 0;
        end else begin
            case (min)
                2'b01: begin
                    bits_q.push_back(sin);
                    if (bits_q.size() == W) begin
                        for (int i = 0; i < W; i++) begin
                            m_pout_l[i]       = bits_q[i];
                            m_pout_m[W-1-i]   = bits_q[i];
                        end
                        if (m_pvalid && !pack) m_ovf = 1;
                        m_pvalid = 1;
                        bits_q.delete();
                    end else if (pack) begin
                        m_pvalid = 0;
                    end
                end
                2'b10, 2'b11: begin
                    bits_q.delete();
                    if (min == 2'b11) m_ovf = 0;
                    if (pack) m_pvalid = 0;
                end
                default: if (pack) m_pvalid = 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_pout_lsb", 32'(pout0), 32'(m_pout_l));
            chk("m_pout_msb", 32'(pout1), 32'(m_pout_m));
            chk("m_pvalid",   32'(pvalid0), 32'(m_pvalid));
            chk("m_pvalid_msb", 32'(pvalid1), 32'(m_pvalid));
            chk("m_ovf",      32'(ovf0), 32'(m_ovf));
            chk("m_busy",     32'(busy0), 32'(bits_q.size() != 0));
            chk("m_bcnt",     32'(bcnt0), 32'(bits_q.size()));
        end
    end

    // Inputs change on a negedge; results are visible at the following negedge.
    task automatic cyc(input logic s, input logic [1:0] m, input logic p);
        sin = s; min = m; pack = p;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic ack_last);
        for (int i = 0; i < W; i++)
            cyc(w[i], 2'b01, (i == W-1) ? ack_last : 1'b0);
    endtask

    initial begin
        rst = 1; sin = 0; min = 2'b00; pack = 0;
        @(negedge clk);
        cyc(0, 2'b00, 0);
        rst = 0;
        chk_en = 1;
        // 1: reset state and idle hold
        for (int i = 0; i < 5; i++) cyc(0, 2'b00, 0);
        chk("rst_pout",   32'(pout0), 0);
        chk("rst_pvalid", 32'(pvalid0), 0);
        chk("rst_busy",   32'(busy0), 0);
        chk("rst_bcnt",   32'(bcnt0), 0);
        chk("rst_ovf",    32'(ovf0), 0);

        // 2: one word, LSB and MSB first
        send_word(8'hA6, 0);  // sin order 0,1,1,0,0,1,0,1
        chk("s2_pout_lsb", 32'(pout0), 32'h0A6);
        chk("s2_pout_msb", 32'(pout1), 32'h065);
        chk("s2_pvalid",   32'(pvalid0), 1);
        cyc(0, 2'b00, 1);
        chk("s2_ack",      32'(pvalid0), 0);

        // 3: hold mid-word, then abort mid-word
        cyc(1, 2'b01, 0); cyc(0, 2'b01, 0); cyc(1, 2'b01, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 2'b00, 0);
            chk("s3_hold_bcnt", 32'(bcnt0), 3);
        end
        chk("s3_hold_busy", 32'(busy0), 1);
        cyc(1, 2'b01, 0); cyc(1, 2'b01, 0); cyc(0, 2'b01, 0);
        cyc(0, 2'b01, 0); cyc(1, 2'b01, 0);
        chk("s3_pout",   32'(pout0), 32'h09D);
        chk("s3_pvalid", 32'(pvalid0), 1);
        cyc(0, 2'b00, 1);
        cyc(1, 2'b01, 0); cyc(1, 2'b01, 0); cyc(1, 2'b01, 0);
        cyc(0, 2'b10, 0);
        chk("s3_abort_bcnt",   32'(bcnt0), 0);
        chk("s3_abort_pvalid", 32'(pvalid0), 0);
        chk("s3_abort_pout",   32'(pout0), 32'h09D);

        // 4: overflow, then resync
        send_word(8'h3C, 0);
        send_word(8'h81, 0);
        chk("s4_pout", 32'(pout0), 32'h081);
        chk("s4_ovf",  32'(ovf0), 1);
        cyc(0, 2'b11, 0);
        chk("s4_resync_ovf",    32'(ovf0), 0);
        chk("s4_resync_pvalid", 32'(pvalid0), 1);

        // 5: ack on the completion edge replaces without overflow
        send_word(8'h5A, 1);
        chk("s5_pout",   32'(pout0), 32'h05A);
        chk("s5_pvalid", 32'(pvalid0), 1);
        chk("s5_ovf",    32'(ovf0), 0);
        cyc(0, 2'b00, 1);

        // 6: reset mid-word, then a clean frame
        cyc(1, 2'b01, 0); cyc(1, 2'b01, 0); cyc(0, 2'b01, 0); cyc(1, 2'b01, 0);
        rst = 1;
        cyc(1, 2'b01, 0);
        rst = 0;
        chk("s6_rst_bcnt",   32'(bcnt0), 0);
        chk("s6_rst_pvalid", 32'(pvalid0), 0);
        chk("s6_rst_pout",   32'(pout0), 0);
        send_word(8'hC3, 0);
        chk("s6_pout",   32'(pout0), 32'h0C3);
        chk("s6_pvalid", 32'(pvalid0), 1);
        send_word(8'h17, 1);
        chk("s6_pout2_msb", 32'(pout1), 32'h0E8);
        cyc(0, 2'b00, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
